// File: rtl/doodle_pkg.sv
// Shared screen geometry, motion constants and the doodle_sm one-hot state codes.
package doodle_pkg;

    localparam int H_RES         = 640;  // visible width
    localparam int V_RES         = 480;  // visible height
    localparam int V_MIDDLE      = 240;  // highest row the doodle may occupy; above this the world scrolls
    localparam int FLOOR_Y       = 510;  // doodle_sm declares DONE when object_y equals this
    localparam int START_X       = 320;
    localparam int START_Y       = 450;
    localparam int H_STEP        = 4;
    localparam int V_STEP        = 1;    // doodle_sm landing checks are equality tests, so this stays 1
    localparam int DOODLE_RADIUS = 20;

    // doodle_sm one-hot state codes, packed as {q_Done, q_Down, q_Up, q_I}
    localparam logic [3:0] I    = 4'b0001;
    localparam logic [3:0] UP   = 4'b0010;
    localparam logic [3:0] DOWN = 4'b0100;
    localparam logic [3:0] DONE = 4'b1000;

    // Decoded per-frame action
    typedef enum logic [2:0] {
        MV_HOLD,    // illegal / no state: keep everything
        MV_INIT,
        MV_UP,
        MV_DOWN,
        MV_FREEZE
    } mv_e;

endpackage

// File: rtl/doodle_sprite_hit.sv
// Registered box test: is the current VGA pixel inside the doodle sprite square?
module doodle_sprite_hit
    import doodle_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic [9:0] object_x,
    input  logic [9:0] object_y,
    output logic       doodle_on
);

    logic [10:0] h11, v11, x11, y11;
    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    logic        hit;

    assign h11 = {1'b0, hCount};
    assign v11 = {1'b0, vCount};
    assign x11 = {1'b0, object_x};
    assign y11 = {1'b0, object_y};

    // Box bounds in 11 bits; lower edges clamp at 0 rather than wrapping
    always_comb begin
        x_lo = (x11 < 11'(DOODLE_RADIUS)) ? 11'd0 : x11 - 11'(DOODLE_RADIUS);
        y_lo = (y11 < 11'(DOODLE_RADIUS)) ? 11'd0 : y11 - 11'(DOODLE_RADIUS);
        x_hi = x11 + 11'(DOODLE_RADIUS);
        y_hi = y11 + 11'(DOODLE_RADIUS);
        hit  = (h11 >= x_lo) && (h11 <= x_hi) && (v11 >= y_lo) && (v11 <= y_hi);
    end

    // One-cycle registered hit flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) doodle_on <= 1'b0;
        else        doodle_on <= hit;
    end

endmodule

// File: rtl/doodle_motion.sv
// Per-frame doodle position update: vertical climb/fall with scroll, horizontal wrap,
// plus the sprite hit flag for the VGA pixel mux.
module doodle_motion
    import doodle_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       q_I,
    input  logic       q_Up,
    input  logic       q_Down,
    input  logic       q_Done,
    input  logic       Left,
    input  logic       Right,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic [9:0] object_x,
    output logic [9:0] object_y,
    output logic [9:0] scroll_y,
    output logic       scroll_pulse,
    output logic       pos_valid,
    output logic       doodle_on
);

    mv_e         mv;
    logic [10:0] x11, y11;
    logic [10:0] l_wrap, l_step, r_step, r_wrap, d_step;
    logic [9:0]  hx, nx, ny, ns;
    logic        nsp;

    assign x11 = {1'b0, object_x};
    assign y11 = {1'b0, object_y};

    // Decode the one-hot state; anything not exactly one-hot holds
    always_comb begin
        case ({q_Done, q_Down, q_Up, q_I})
            I:       mv = MV_INIT;
            UP:      mv = MV_UP;
            DOWN:    mv = MV_DOWN;
            DONE:    mv = MV_FREEZE;
            default: mv = MV_HOLD;
        endcase
    end

    // Horizontal candidate: step with wrap so x stays in [0, H_RES-1]
    always_comb begin
        l_wrap = x11 + 11'(H_RES - H_STEP);
        l_step = x11 - 11'(H_STEP);
        r_step = x11 + 11'(H_STEP);
        r_wrap = r_step - 11'(H_RES);
        hx     = object_x;
        if (Left && !Right)
            hx = (x11 < 11'(H_STEP)) ? l_wrap[9:0] : l_step[9:0];
        else if (Right && !Left)
            hx = (r_step >= 11'(H_RES)) ? r_wrap[9:0] : r_step[9:0];
    end

    // Next-frame position, scroll and scroll strobe
    always_comb begin
        nx     = object_x;
        ny     = object_y;
        ns     = scroll_y;
        nsp    = 1'b0;
        d_step = y11 + 11'(V_STEP);
        case (mv)
            MV_INIT: begin
                nx = 10'(START_X);
                ny = 10'(START_Y);
                ns = 10'd0;
            end
            MV_UP: begin
                nx = hx;
                // Climbing above the middle row turns into world scroll
                if (y11 >= 11'(V_MIDDLE + V_STEP)) begin
                    ny = object_y - 10'(V_STEP);
                end else begin
                    ns  = scroll_y + 10'(V_STEP);
                    nsp = 1'b1;
                end
            end
            MV_DOWN: begin
                nx = hx;
                // Saturate exactly on FLOOR_Y so the equality landing test fires
                ny = (d_step >= 11'(FLOOR_Y)) ? 10'(FLOOR_Y) : d_step[9:0];
            end
            default: ;
        endcase
    end

    // Frame registers: only move on frame_tick; pos_valid/scroll_pulse strobe the cycle after
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            object_x     <= 10'(START_X);
            object_y     <= 10'(START_Y);
            scroll_y     <= 10'd0;
            scroll_pulse <= 1'b0;
            pos_valid    <= 1'b0;
        end else if (frame_tick) begin
            object_x     <= nx;
            object_y     <= ny;
            scroll_y     <= ns;
            scroll_pulse <= nsp;
            pos_valid    <= 1'b1;
        end else begin
            scroll_pulse <= 1'b0;
            pos_valid    <= 1'b0;
        end
    end

    doodle_sprite_hit u_hit (
        .Clk       (Clk),
        .Reset     (Reset),
        .hCount    (hCount),
        .vCount    (vCount),
        .object_x  (object_x),
        .object_y  (object_y),
        .doodle_on (doodle_on)
    );

endmodule

// File: tb/tb_doodle_motion.sv
// Scoreboard bench for doodle_motion: frame ticks push expected positions, a monitor
// pops and compares on every pos_valid strobe.
module tb_doodle_motion;
    import doodle_pkg::*;

    logic       Clk = 1'b0, Reset = 1'b0, frame_tick = 1'b0;
    logic       q_I = 1'b0, q_Up = 1'b0, q_Down = 1'b0, q_Done = 1'b0;
    logic       Left = 1'b0, Right = 1'b0;
    logic [9:0] hCount = '0, vCount = '0;
    logic [9:0] object_x, object_y, scroll_y;
    logic       scroll_pulse, pos_valid, doodle_on;

    doodle_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
        .Left(Left), .Right(Right), .hCount(hCount), .vCount(vCount),
        .object_x(object_x), .object_y(object_y), .scroll_y(scroll_y),
        .scroll_pulse(scroll_pulse), .pos_valid(pos_valid), .doodle_on(doodle_on)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] s;
        logic       sp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pv_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every pos_valid strobe consumes one expected frame result
    always @(negedge Clk) begin
        if (Reset && pos_valid) begin
            pv_count++;
            if (sb.size() == 0) begin
                chk("unexpected_pos_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("object_x", 32'(object_x), 32'(e.x));
                chk("object_y", 32'(object_y), 32'(e.y));
                chk("scroll_y", 32'(scroll_y), 32'(e.s));
                chk("scroll_pulse", 32'(scroll_pulse), 32'(e.sp));
            end
        end
    end

    task automatic tick(input logic [3:0] q, input logic l, input logic r,
                        input int ex, input int ey, input int es, input logic sp);
        exp_t e;
        @(negedge Clk);
        frame_tick = 1'b1;
        {q_Done, q_Down, q_Up, q_I} = q;
        Left  = l;
        Right = r;
        e.x = 10'(ex); e.y = 10'(ey); e.s = 10'(es); e.sp = sp;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge Clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic spr(input string name, input int h, input int v, input logic exp);
        @(negedge Clk);
        hCount = 10'(h);
        vCount = 10'(v);
        @(negedge Clk);
        chk(name, 32'(doodle_on), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv0;
        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_x", 32'(object_x), 32'd320);
        chk("rst_y", 32'(object_y), 32'd450);
        chk("rst_scroll", 32'(scroll_y), 32'd0);
        chk("rst_sp", 32'(scroll_pulse), 32'd0);
        chk("rst_pv", 32'(pos_valid), 32'd0);
        chk("rst_on", 32'(doodle_on), 32'd0);
        Reset = 1'b1;
        idle(2);

        tick(I, 1'b0, 1'b0, 320, 450, 0, 1'b0);
        // Climb while walking left to x=0
        for (int k = 1; k <= 80; k++) tick(UP, 1'b1, 1'b0, 320 - 4*k, 450 - k, 0, 1'b0);
        tick(UP, 1'b1, 1'b0, 636, 369, 0, 1'b0);   // left wrap from 0
        tick(UP, 1'b0, 1'b1, 0, 368, 0, 1'b0);     // right wrap from 636
        tick(UP, 1'b1, 1'b1, 0, 367, 0, 1'b0);     // both pressed: hold x
        for (int k = 1; k <= 125; k++) tick(UP, 1'b0, 1'b0, 0, 367 - k, 0, 1'b0);
        // y=242: reach middle, then scroll
        tick(UP, 1'b0, 1'b0, 0, 241, 0, 1'b0);
        tick(UP, 1'b0, 1'b0, 0, 240, 0, 1'b0);
        tick(UP, 1'b0, 1'b0, 0, 240, 1, 1'b1);
        tick(UP, 1'b0, 1'b0, 0, 240, 2, 1'b1);
        // Fall to the floor and saturate
        for (int k = 1; k <= 269; k++) tick(DOWN, 1'b0, 1'b0, 0, 240 + k, 2, 1'b0);
        tick(DOWN, 1'b0, 1'b0, 0, 510, 2, 1'b0);
        tick(DOWN, 1'b0, 1'b0, 0, 510, 2, 1'b0);
        idle(1);
        drain();

        // Done freezes even with Left held; pos_valid still strobes each frame
        pv0 = pv_count;
        for (int k = 0; k < 5; k++) tick(DONE, 1'b1, 1'b0, 0, 510, 2, 1'b0);
        idle(1);
        drain();
        chk("done_pv_pulses", 32'(pv_count - pv0), 32'd5);

        // Illegal state codes hold
        tick(4'b0011, 1'b1, 1'b0, 0, 510, 2, 1'b0);
        tick(4'b0000, 1'b0, 1'b1, 0, 510, 2, 1'b0);
        idle(1);
        drain();

        // Asynchronous reset mid-cycle
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_x", 32'(object_x), 32'd320);
        chk("mid_rst_y", 32'(object_y), 32'd450);
        chk("mid_rst_scroll", 32'(scroll_y), 32'd0);
        chk("mid_rst_pv", 32'(pos_valid), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("post_rst_pv", 32'(pos_valid), 32'd0);
        end
        tick(I, 1'b1, 1'b0, 320, 450, 0, 1'b0);
        idle(1);
        drain();

        // Sprite box around (320,450), inclusive edges
        spr("spr_corner_lo", 300, 430, 1'b1);
        spr("spr_left_out", 299, 430, 1'b0);
        spr("spr_corner_hi", 340, 470, 1'b1);
        spr("spr_right_out", 341, 470, 1'b0);
        spr("spr_below_out", 320, 471, 1'b0);

        // Walk left while falling: x=8, y saturates at 510
        for (int k = 1; k <= 78; k++)
            tick(DOWN, 1'b1, 1'b0, 320 - 4*k, (450 + k > 510) ? 510 : 450 + k, 0, 1'b0);
        idle(1);
        drain();
        spr("spr_clamp_x0", 0, 490, 1'b1);
        spr("spr_x_hi_edge", 28, 530, 1'b1);
        spr("spr_x_hi_out", 29, 500, 1'b0);
        spr("spr_y_lo_out", 0, 489, 1'b0);

        // No frame_tick: positions stay put even with a button held
        Left = 1'b1;
        q_Up = 1'b1; q_Down = 1'b0; q_I = 1'b0; q_Done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            chk("hold_x", 32'(object_x), 32'd8);
            chk("hold_y", 32'(object_y), 32'd510);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/doodle_motion.md
Name: doodle_motion

Overview:
- Drives the doodle's on-screen position: produces the object_x/object_y that doodle_sm consumes, plus the VGA hit flag for the doodle sprite.
- Follows doodle_sm's one-hot state outputs (q_I/q_Up/q_Down/q_Done) and the player's left/right buttons.
- Updates position once per video frame and scrolls the world once the doodle reaches the screen middle.
- Sits between doodle_sm and the VGA pixel mux.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- V_MIDDLE, 240, topmost row the doodle may occupy; higher climbs become scroll
- FLOOR_Y, 510, object_y value at which doodle_sm declares DONE
- START_X, 320, object_x held in I
- START_Y, 450, object_y held in I
- H_STEP, 4, horizontal pixels per frame
- V_STEP, 1, vertical pixels per frame; must stay 1 because doodle_sm landing checks are equality-based
- DOODLE_RADIUS, 20, half-size of the square sprite

Ports:
- Clk, in, 1, system clock
- Reset, in, 1, asynchronous active-low reset
- frame_tick, in, 1, one-cycle pulse per frame (vsync edge)
- q_I, q_Up, q_Down, q_Done, in, 1 each, doodle_sm one-hot state
- Left, Right, in, 1 each, debounced button levels
- hCount, vCount, in, 10 each, current VGA pixel coordinate
- object_x, object_y, out, 10 each, doodle centre position
- scroll_y, out, 10, accumulated world scroll, mod 1024
- scroll_pulse, out, 1, one-cycle pulse on a frame where scroll_y advanced
- pos_valid, out, 1, one-cycle pulse the cycle after any frame update
- doodle_on, out, 1, current pixel lies inside the sprite box

Behaviour:
- Reset low, asynchronously:
  - object_x=START_X, object_y=START_Y
  - scroll_y=0, scroll_pulse=0, pos_valid=0, doodle_on=0
- Frame update:
  - object_x, object_y and scroll_y change only on a Clk edge where frame_tick=1.
  - They are stable all other cycles, so there is no tearing mid-frame.
  - pos_valid=1 exactly one cycle after each frame_tick update, every frame including frozen ones.
- State mux: sample the q_* inputs on the frame_tick cycle. If none or more than one is high (illegal), hold all positions.
- I:
  - object_x=START_X, object_y=START_Y, scroll_y=0.
  - Ignore the buttons.
- Up:
  - If object_y-V_STEP >= V_MIDDLE: object_y -= V_STEP.
  - Otherwise hold object_y, add V_STEP to scroll_y, and assert scroll_pulse for that cycle.
- Down:
  - object_y += V_STEP, saturating at FLOOR_Y.
  - Never exceed FLOOR_Y, so doodle_sm's ==FLOOR_Y test always fires.
  - Once saturated, hold object_y at FLOOR_Y.
- Done: freeze all positions; no scroll.
- Horizontal movement (Up or Down states only):
  - Left only: object_x -= H_STEP. If object_x < H_STEP, wrap to object_x + H_RES - H_STEP.
  - Right only: object_x += H_STEP. If the result is >= H_RES, subtract H_RES.
  - Both or neither pressed: hold object_x.
  - object_x always stays in [0, H_RES-1].
- Arithmetic:
  - All comparisons use 11-bit unsigned intermediates to avoid 10-bit wrap.
  - scroll_y wraps naturally 1023 -> 0.
- Sprite hit:
  - doodle_on is registered, with 1-cycle latency from hCount/vCount.
  - Set when hCount is in [object_x-DOODLE_RADIUS, object_x+DOODLE_RADIUS] and vCount is in [object_y-DOODLE_RADIUS, object_y+DOODLE_RADIUS], both inclusive.
  - Lower bounds clamp at 0; no underflow wrap.
- Simultaneous events: a state change on the same cycle as frame_tick uses the q_* values present on that cycle.
- Reset mid-frame: outputs return to reset values immediately; the next update comes on the next frame_tick after release.

Decomposition:
- doodle_pkg holds:
  - screen constants H_RES, V_RES, V_MIDDLE, FLOOR_Y
  - state one-hot localparams I=0001, UP=0010, DOWN=0100, DONE=1000, shared with doodle_sm
- Sub-module doodle_sprite_hit: registered box test from (hCount, vCount, object_x, object_y, DOODLE_RADIUS) to doodle_on.
- doodle_motion contains the frame-update registers and the wrap/saturate logic.

Test Plan:
- Reset pulse low mid-run -> object_x=320, object_y=450, scroll_y=0 in the same cycle. pos_valid=0 until the first frame_tick after release.
- q_Up, object_y=242, three frame_ticks -> object_y 241, 240, then held at 240. scroll_y becomes 1 with one scroll_pulse on the third tick.
- q_Down, object_y=509, two frame_ticks -> 510, then held at 510; never reaches 511.
- q_Up, Left=1, object_x=2 -> object_x=638. Then Right=1, object_x=638 -> object_x=2. Left=Right=1 -> no change.
- q_Done with Left=1, five frame_ticks -> all positions constant, pos_valid pulses 5 times. Then q_I -> object_x=320, object_y=450, scroll_y=0.
- object_x=10, object_y=450: hCount=0, vCount=430 -> doodle_on=1 one cycle later. hCount=31 -> 0. frame_tick absent -> object_x/object_y never change.
